// File: rtl/rv_pkg.sv
// rv_pkg: fetch-stage state encoding and shared constants
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_e;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: chooses sequential pc+4 or the word-aligned redirect target
module pc_next_sel
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pc_src,
    input  logic [XLEN-1:0] i_branch_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misalign
);
    always_comb begin
        o_next_pc  = i_pc_src ? (i_branch_target & ~32'h3) : i_pc + 32'd4;
        o_misalign = i_pc_src & |i_branch_target[1:0];
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one outstanding imem fetch at a time and
// holds the fetched {instr, pc} for decode; a redirect squashes in-flight work.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic            fetch_misalign
);
    fetch_state_e    r_state, w_state_n;
    logic [XLEN-1:0] r_pc, r_instr, r_ipc, w_next_pc;
    logic            r_squash, w_squash_n, w_cap, r_misalign, w_misalign, w_drop;

    pc_next_sel u_pc_next_sel (
        .i_pc            (r_pc),
        .i_pc_src        (pc_src),
        .i_branch_target (branch_target),
        .o_next_pc       (w_next_pc),
        .o_misalign      (w_misalign)
    );

    // A response that arrives with a redirect pending or already squashed is stale.
    assign w_drop = r_squash | pc_src;

    always_comb begin
        w_state_n  = r_state;
        w_squash_n = r_squash;
        w_cap      = 1'b0;
        unique case (r_state)
            S_REQ: begin
                w_state_n  = imem_req_ready ? S_WAIT : S_REQ;
                w_squash_n = imem_req_ready & pc_src;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_n  = w_drop ? S_REQ : S_HOLD;
                    w_squash_n = 1'b0;
                    w_cap      = ~w_drop;
                end else if (pc_src) begin
                    w_squash_n = 1'b1;
                end
            end
            S_HOLD:  w_state_n = (pc_src | instr_ready) ? S_REQ : S_HOLD;
            default: w_state_n = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_squash   <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_ipc      <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_squash   <= w_squash_n;
            r_misalign <= w_misalign;
            if (pc_src | w_cap)
                r_pc <= w_next_pc;
            if (w_cap) begin
                r_instr <= imem_rsp_data;
                r_ipc   <= r_pc;
            end
        end
    end

    assign imem_req_valid = (r_state == S_REQ) & ~rst;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = (r_state == S_HOLD);
    assign instr_out      = r_instr;
    assign instr_pc       = r_ipc;
    assign instr_pc_plus4 = r_ipc + 32'd4;
    assign fetch_misalign = r_misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a latency-configurable imem model
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        pc_src, req_valid, mem_ready, rsp_valid, instr_valid, instr_ready, fetch_misalign;
    logic [31:0] branch_target, req_addr, rsp_data, instr_out, instr_pc, instr_pc_plus4;
    logic        req_valid2, rsp_valid2, instr_valid2, instr_ready2, misalign2;
    logic [31:0] req_addr2, rsp_data2, instr_out2, instr_pc2, plus4_2;

    int checks = 0, failures = 0, n_acc = 0, n_con = 0, lat = 1;
    logic [31:0] squash_pc = 32'h0000_0001;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .branch_target(branch_target),
        .imem_req_valid(req_valid), .imem_req_ready(mem_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4), .fetch_misalign(fetch_misalign)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk(clk), .rst(rst), .pc_src(1'b0), .branch_target(32'h0),
        .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_req_addr(req_addr2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr_out(instr_out2),
        .instr_pc(instr_pc2), .instr_pc_plus4(plus4_2), .fetch_misalign(misalign2)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // imem model for the main DUT: response after lat cycles, cleared by reset
    logic        pend;
    int          cnt;
    logic [31:0] maddr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0; cnt <= 0; maddr <= 32'h0;
        end else begin
            if (pend) begin
                if (cnt == 1) pend <= 1'b0;
                else cnt <= cnt - 1;
            end
            if (req_valid && mem_ready) begin
                pend <= 1'b1; cnt <= lat; maddr <= req_addr;
            end
        end
    end
    assign rsp_valid = pend && (cnt == 1);
    assign rsp_data  = rsp_valid ? mdata(maddr) : 32'h0;

    // imem model for the wrap-around DUT: always ready, one-cycle latency
    logic        pend2;
    logic [31:0] maddr2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend2 <= 1'b0; maddr2 <= 32'h0;
        end else begin
            pend2 <= req_valid2; maddr2 <= req_addr2;
        end
    end
    assign rsp_valid2 = pend2;
    assign rsp_data2  = mdata(maddr2);

    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (!rst) begin
            if (req_valid && mem_ready) begin
                n_acc++;
                if (exp_addr_q.size() != 0) e = exp_addr_q.pop_front();
                else e = ~req_addr;
                chk("req_addr", req_addr, e);
            end
            if (instr_valid && instr_ready && !pc_src) begin
                n_con++;
                if (exp_pc_q.size() != 0) e = exp_pc_q.pop_front();
                else e = ~instr_pc;
                chk("instr_pc", instr_pc, e);
                chk("instr_out", instr_out, mdata(e));
                chk("pc_plus4", instr_pc_plus4, e + 32'd4);
            end
            if (instr_valid)
                chk("squashed_pc_seen", {31'b0, instr_pc == squash_pc}, 32'h0);
        end
    end

    task automatic wait_hold(input string tag);
        int k = 0;
        while (!instr_valid && k < 50) begin tick(); k++; end
        chk(tag, {31'b0, instr_valid}, 32'h1);
    endtask

    task automatic wait_acc(input int n0);
        int k = 0;
        while (n_acc == n0 && k < 50) begin tick(); k++; end
        chk("acc_timeout", {31'b0, n_acc != n0}, 32'h1);
    endtask

    task automatic wait_con(input int n0);
        int k = 0;
        while (n_con == n0 && k < 50) begin tick(); k++; end
        chk("con_timeout", {31'b0, n_con != n0}, 32'h1);
    endtask

    initial begin
        int n0;
        int k;
        rst = 1'b1; pc_src = 1'b0; branch_target = 32'h0;
        mem_ready = 1'b1; instr_ready = 1'b0; instr_ready2 = 1'b0;
        tick(); tick();
        chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pc_plus4", instr_pc_plus4, 32'h4);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
        chk("rst2_instr_pc", instr_pc2, 32'hFFFF_FFFC);
        chk("rst2_pc_plus4", plus4_2, 32'h0);
        chk("rst2_req_valid", {31'b0, req_valid2}, 32'h0);

        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8); exp_addr_q.push_back(32'hC);
        exp_pc_q.push_back(32'h0); exp_pc_q.push_back(32'h4); exp_pc_q.push_back(32'h8);
        instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("wrap_first_valid", {31'b0, req_valid2}, 32'h1);
        chk("wrap_first_addr", req_addr2, 32'hFFFF_FFFC);
        k = 0;
        while (n_con < 3 && k < 100) begin tick(); k++; end
        chk("seq_count", n_con, 32'd3);
        instr_ready = 1'b0;
        wait_hold("hold_c_timeout");

        repeat (5) begin
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
            chk("stall_pc", instr_pc, 32'hC);
            chk("stall_instr", instr_out, mdata(32'hC));
            chk("stall_no_req", {31'b0, req_valid}, 32'h0);
            tick();
        end

        chk("wrap_hold_valid", {31'b0, instr_valid2}, 32'h1);
        chk("wrap_hold_pc", instr_pc2, 32'hFFFF_FFFC);
        chk("wrap_hold_plus4", plus4_2, 32'h0);
        chk("wrap_hold_instr", instr_out2, mdata(32'hFFFF_FFFC));
        instr_ready2 = 1'b1;
        tick();
        instr_ready2 = 1'b0;
        chk("wrap_next_valid", {31'b0, req_valid2}, 32'h1);
        chk("wrap_next_addr", req_addr2, 32'h0);

        exp_addr_q.push_back(32'h200);
        pc_src = 1'b1; branch_target = 32'h200; instr_ready = 1'b1;
        tick();
        pc_src = 1'b0; instr_ready = 1'b0;
        chk("hold_redir_valid", {31'b0, instr_valid}, 32'h0);
        chk("hold_redir_addr", req_addr, 32'h200);
        chk("hold_redir_misalign", {31'b0, fetch_misalign}, 32'h0);
        wait_hold("hold_200_timeout");
        chk("tgt_pc", instr_pc, 32'h200);
        chk("tgt_plus4", instr_pc_plus4, 32'h204);

        lat = 3;
        exp_pc_q.push_back(32'h200);
        exp_addr_q.push_back(32'h204);
        exp_addr_q.push_back(32'h100);
        n0 = n_acc;
        instr_ready = 1'b1;
        wait_acc(n0);
        pc_src = 1'b1; branch_target = 32'h100; instr_ready = 1'b0; squash_pc = 32'h204;
        tick();
        pc_src = 1'b0;
        wait_hold("hold_100_timeout");
        chk("squash_pc", instr_pc, 32'h100);
        chk("squash_instr", instr_out, mdata(32'h100));

        exp_addr_q.push_back(32'h100);
        pc_src = 1'b1; branch_target = 32'h102;
        tick();
        pc_src = 1'b0;
        chk("misalign_pulse", {31'b0, fetch_misalign}, 32'h1);
        chk("misalign_addr", req_addr, 32'h100);
        tick();
        chk("misalign_clear", {31'b0, fetch_misalign}, 32'h0);
        wait_hold("hold_mis_timeout");
        chk("misalign_pc", instr_pc, 32'h100);

        mem_ready = 1'b0;
        exp_pc_q.push_back(32'h100);
        n0 = n_con;
        instr_ready = 1'b1;
        wait_con(n0);
        instr_ready = 1'b0;
        repeat (3) begin
            chk("req_hold_valid", {31'b0, req_valid}, 32'h1);
            chk("req_hold_addr", req_addr, 32'h104);
            tick();
        end

        exp_addr_q.push_back(32'h104);
        n0 = n_acc;
        mem_ready = 1'b1;
        wait_acc(n0);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", {31'b0, req_valid}, 32'h0);
        chk("arst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_instr_out", instr_out, 32'h0000_0013);
        chk("arst_instr_pc", instr_pc, 32'h0);
        chk("arst_pc_plus4", instr_pc_plus4, 32'h4);
        chk("arst2_instr_pc", instr_pc2, 32'hFFFF_FFFC);
        chk("arst2_instr_valid", {31'b0, instr_valid2}, 32'h0);

        chk("addr_q_left", 32'(exp_addr_q.size()), 32'h0);
        chk("pc_q_left", 32'(exp_pc_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
